// File: rtl/rbcp_pkg.sv
// Shared types and helpers for the RBCP register responder.
package rbcp_pkg;

  localparam int unsigned RBCP_DW = 8;
  localparam int unsigned RBCP_AW = 32;

  typedef enum logic [1:0] {
    IDLE,
    EXT_REQ,
    EXT_WAIT,
    RESP
  } rbcp_state_e;

  typedef enum logic [1:0] {
    LOCAL,
    EXT,
    UNMAPPED
  } rbcp_dec_e;

  // Offset is formed on 33 bits so base + 2**aw may exceed 32 bits without wrap.
  function automatic logic in_window(input logic [RBCP_AW-1:0] addr,
                                     input logic [RBCP_AW-1:0] base,
                                     input int unsigned        aw);
    logic [RBCP_AW:0] span;
    logic [RBCP_AW:0] off;
    span = {{RBCP_AW{1'b0}}, 1'b1} << aw;
    off  = {1'b0, addr - base};
    return (addr >= base) && (off < span);
  endfunction

  function automatic rbcp_dec_e rbcp_decode(input logic [RBCP_AW-1:0] addr,
                                            input logic [RBCP_AW-1:0] loc_base,
                                            input int unsigned        loc_aw,
                                            input logic [RBCP_AW-1:0] ext_base,
                                            input int unsigned        ext_aw);
    if (in_window(addr, loc_base, loc_aw)) return LOCAL;
    if (in_window(addr, ext_base, ext_aw)) return EXT;
    return UNMAPPED;
  endfunction

endpackage

// File: rtl/rbcp_regfile.sv
// Byte-wide local register file: offset 0 is a fixed ID byte, registered read port,
// all bytes exported as one flat vector.
module rbcp_regfile
  import rbcp_pkg::*;
#(
  parameter int unsigned          AW       = 4,
  parameter logic [RBCP_DW-1:0]   ID_VALUE = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [RBCP_DW-1:0]            wr_data,
  input  logic                          rd_en,
  input  logic [AW-1:0]                 rd_addr,
  output logic [RBCP_DW-1:0]            rd_data,
  output logic [RBCP_DW*(2**AW)-1:0]    reg_out
);

  localparam int unsigned DEPTH = 2**AW;

  logic [RBCP_DW-1:0] mem_q [DEPTH];
  logic [RBCP_DW-1:0] mem_d [DEPTH];
  logic [RBCP_DW-1:0] rd_q;
  logic [RBCP_DW-1:0] rd_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    if (wr_en && (wr_addr != '0)) mem_d[wr_addr] = wr_data;
    if (rd_en) rd_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i == 0) ? ID_VALUE : '0;
      end
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      reg_out[RBCP_DW*i +: RBCP_DW] = mem_q[i];
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/rbcp_reg_slave.sv
// SiTCP RBCP responder: local register file plus an external req/ack window
// with a bounded wait.
module rbcp_reg_slave
  import rbcp_pkg::*;
#(
  parameter logic [31:0] LOC_BASE    = 32'h0000_0000,
  parameter int unsigned LOC_AW      = 4,
  parameter logic [31:0] EXT_BASE    = 32'h0000_1000,
  parameter int unsigned EXT_AW      = 8,
  parameter logic [15:0] EXT_TIMEOUT = 16'd1000,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        RBCP_ACT,
  input  logic [31:0]                 RBCP_ADDR,
  input  logic                        RBCP_WE,
  input  logic [7:0]                  RBCP_WD,
  input  logic                        RBCP_RE,
  output logic                        RBCP_ACK,
  output logic [7:0]                  RBCP_RD,
  output logic [8*(2**LOC_AW)-1:0]    REG_OUT,
  output logic [EXT_AW-1:0]           EXT_ADDR,
  output logic                        EXT_WE,
  output logic                        EXT_RE,
  output logic [7:0]                  EXT_WD,
  input  logic                        EXT_ACK,
  input  logic [7:0]                  EXT_RD,
  output logic                        TIMEOUT_ERR
);

  rbcp_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        ext_we_q, ext_we_d;
  logic        ext_re_q, ext_re_d;
  logic [EXT_AW-1:0] ext_addr_q, ext_addr_d;
  logic [7:0]  ext_wd_q, ext_wd_d;
  logic        is_rd_q, is_rd_d;
  logic [7:0]  ext_rd_q, ext_rd_d;
  logic        rd_sel_q, rd_sel_d;
  logic        tmo_q, tmo_d;

  logic        we_s, re_s;
  rbcp_dec_e   dec;
  logic [LOC_AW-1:0] loc_off;
  logic [EXT_AW-1:0] ext_off;
  logic        rf_we, rf_re;
  logic [7:0]  loc_rd;

  // Write wins over a simultaneous read.
  assign we_s    = RBCP_ACT & RBCP_WE;
  assign re_s    = RBCP_ACT & RBCP_RE & ~RBCP_WE;
  assign dec     = rbcp_decode(RBCP_ADDR, LOC_BASE, LOC_AW, EXT_BASE, EXT_AW);
  assign loc_off = LOC_AW'(RBCP_ADDR - LOC_BASE);
  assign ext_off = EXT_AW'(RBCP_ADDR - EXT_BASE);

  rbcp_regfile #(
    .AW       (LOC_AW),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (rf_we),
    .wr_addr (loc_off),
    .wr_data (RBCP_WD),
    .rd_en   (rf_re),
    .rd_addr (loc_off),
    .rd_data (loc_rd),
    .reg_out (REG_OUT)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    ext_we_d   = 1'b0;
    ext_re_d   = 1'b0;
    ext_addr_d = ext_addr_q;
    ext_wd_d   = ext_wd_q;
    is_rd_d    = is_rd_q;
    ext_rd_d   = ext_rd_q;
    rd_sel_d   = rd_sel_q;
    tmo_d      = 1'b0;
    rf_we      = 1'b0;
    rf_re      = 1'b0;

    case (state_q)
      IDLE: begin
        if (we_s || re_s) begin
          case (dec)
            LOCAL: begin
              rf_we   = we_s;
              rf_re   = re_s;
              if (re_s) rd_sel_d = 1'b0;
              ack_d   = 1'b1;
              state_d = RESP;
            end
            EXT: begin
              ext_addr_d = ext_off;
              ext_wd_d   = RBCP_WD;
              ext_we_d   = we_s;
              ext_re_d   = re_s;
              is_rd_d    = re_s;
              cnt_d      = '0;
              state_d    = EXT_REQ;
            end
            default: ;
          endcase
        end
      end
      // EXT_REQ is the strobe cycle; it waits exactly like EXT_WAIT so the
      // timeout count includes it.
      EXT_REQ, EXT_WAIT: begin
        if (!RBCP_ACT) begin
          state_d = IDLE;
        end else if (EXT_ACK) begin
          ext_rd_d = is_rd_q ? EXT_RD : '0;
          rd_sel_d = 1'b1;
          ack_d    = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == EXT_TIMEOUT - 16'd1) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          state_d = EXT_WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      ext_we_q   <= 1'b0;
      ext_re_q   <= 1'b0;
      ext_addr_q <= '0;
      ext_wd_q   <= '0;
      is_rd_q    <= 1'b0;
      ext_rd_q   <= '0;
      rd_sel_q   <= 1'b1;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      ext_we_q   <= ext_we_d;
      ext_re_q   <= ext_re_d;
      ext_addr_q <= ext_addr_d;
      ext_wd_q   <= ext_wd_d;
      is_rd_q    <= is_rd_d;
      ext_rd_q   <= ext_rd_d;
      rd_sel_q   <= rd_sel_d;
      tmo_q      <= tmo_d;
    end
  end

  assign RBCP_ACK    = ack_q;
  assign RBCP_RD     = rd_sel_q ? ext_rd_q : loc_rd;
  assign EXT_WE      = ext_we_q;
  assign EXT_RE      = ext_re_q;
  assign EXT_ADDR    = ext_addr_q;
  assign EXT_WD      = ext_wd_q;
  assign TIMEOUT_ERR = tmo_q;

endmodule

// File: tb/tb_rbcp_reg_slave.sv
// Scoreboard bench for rbcp_reg_slave: directed scenarios plus random traffic
// checked against a byte-array model of the register map.
module tb_rbcp_reg_slave;

  localparam int unsigned NREG     = 16;
  localparam logic [31:0] EXT_BASE = 32'h0000_1000;
  localparam int unsigned EXT_SPAN = 256;
  localparam int unsigned TMO      = 1000;
  localparam logic [7:0]  ID       = 8'hA5;

  logic         clk = 1'b0;
  logic         rst;
  logic         act, we_i, re_i;
  logic [31:0]  addr_i;
  logic [7:0]   wd_i;
  logic         rbcp_ack;
  logic [7:0]   rbcp_rd;
  logic [127:0] reg_out;
  logic [7:0]   ext_addr;
  logic         ext_we, ext_re;
  logic [7:0]   ext_wd;
  logic         ext_ack;
  logic [7:0]   ext_rd;
  logic         timeout_err;

  always #4 clk = ~clk;

  rbcp_reg_slave #(
    .LOC_BASE    (32'h0000_0000),
    .LOC_AW      (4),
    .EXT_BASE    (EXT_BASE),
    .EXT_AW      (8),
    .EXT_TIMEOUT (16'd1000),
    .ID_VALUE    (ID)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .RBCP_ACT    (act),
    .RBCP_ADDR   (addr_i),
    .RBCP_WE     (we_i),
    .RBCP_WD     (wd_i),
    .RBCP_RE     (re_i),
    .RBCP_ACK    (rbcp_ack),
    .RBCP_RD     (rbcp_rd),
    .REG_OUT     (reg_out),
    .EXT_ADDR    (ext_addr),
    .EXT_WE      (ext_we),
    .EXT_RE      (ext_re),
    .EXT_WD      (ext_wd),
    .EXT_ACK     (ext_ack),
    .EXT_RD      (ext_rd),
    .TIMEOUT_ERR (timeout_err)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned ack_cnt = 0;
  int unsigned tmo_cnt = 0;
  int unsigned strobe_cnt = 0;
  int unsigned t_strobe = 0;
  int unsigned t_tmo = 0;

  typedef struct {
    logic [7:0] rd;
    bit         chk;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] model_mem [NREG];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rbcp_ack === 1'b1) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) check("rbcp_rd", rbcp_rd, e.rd);
      end
    end
    if (timeout_err === 1'b1) begin
      tmo_cnt++;
      t_tmo = cyc;
    end
    if (ext_we === 1'b1 || ext_re === 1'b1) begin
      strobe_cnt++;
      t_strobe = cyc;
    end
  end

  // 0 = local, 1 = external window, 2 = unmapped
  function automatic int kind_of(input logic [31:0] a);
    if (a < NREG) return 0;
    if (a >= EXT_BASE && a < EXT_BASE + EXT_SPAN) return 1;
    return 2;
  endfunction

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    for (int i = 0; i < NREG; i++) v[8*i +: 8] = model_mem[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model_mem[i] = 8'h00;
    model_mem[0] = ID;
  endtask

  task automatic start_strobe(input logic we, input logic re, input logic [31:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    act = 1'b1; we_i = we; re_i = re; addr_i = a; wd_i = d;
    @(posedge clk); #1;
    we_i = 1'b0; re_i = 1'b0;
  endtask

  task automatic wait_ack(input int unsigned base, input string name);
    for (int i = 0; i < 12; i++) begin
      if (ack_cnt > base) break;
      @(posedge clk); #2;
    end
    check(name, (ack_cnt > base), 1);
  endtask

  task automatic local_access(input logic we, input logic re, input logic [31:0] a, input logic [7:0] d);
    exp_t e;
    int unsigned b;
    int unsigned off;
    b   = ack_cnt;
    off = a % NREG;
    if (we) begin
      e.chk = 1'b0; e.rd = 8'h00;
      if (off != 0) model_mem[off] = d;
    end else begin
      e.chk = 1'b1; e.rd = model_mem[off];
    end
    exp_q.push_back(e);
    start_strobe(we, re, a, d);
    wait_ack(b, "local_ack");
    act = 1'b0;
    if (we) check("reg_out", reg_out, model_vec());
  endtask

  task automatic ext_access(input logic we, input logic [31:0] a, input logic [7:0] d,
                            input int unsigned delay, input logic [7:0] data);
    exp_t e;
    int unsigned b, sb;
    b  = ack_cnt;
    sb = strobe_cnt;
    e.chk = 1'b1;
    e.rd  = we ? 8'h00 : data;
    exp_q.push_back(e);
    start_strobe(we, !we, a, d);
    check("ext_we", ext_we, we);
    check("ext_re", ext_re, !we);
    check("ext_addr", ext_addr, a - EXT_BASE);
    if (we) check("ext_wd", ext_wd, d);
    repeat (delay) begin @(posedge clk); #1; end
    ext_ack = 1'b1; ext_rd = data;
    @(posedge clk); #1;
    ext_ack = 1'b0; ext_rd = 8'($urandom);
    wait_ack(b, "ext_ack");
    act = 1'b0;
    check("ext_strobe_count", strobe_cnt - sb, 1);
  endtask

  task automatic unmapped_access(input logic we, input logic re, input logic [31:0] a);
    int unsigned b, sb;
    b  = ack_cnt;
    sb = strobe_cnt;
    start_strobe(we, re, a, 8'h5A);
    repeat (6) begin @(posedge clk); #1; end
    act = 1'b0;
    check("unmapped_no_ack", ack_cnt - b, 0);
    check("unmapped_no_ext", strobe_cnt - sb, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, rbcp_ack, 0);
    check({tag, "_rd"}, rbcp_rd, 0);
    check({tag, "_ext_we"}, ext_we, 0);
    check({tag, "_ext_re"}, ext_re, 0);
    check({tag, "_ext_addr"}, ext_addr, 0);
    check({tag, "_ext_wd"}, ext_wd, 0);
    check({tag, "_timeout"}, timeout_err, 0);
    check({tag, "_reg_out"}, reg_out, model_vec());
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned b, tb, sb;
    logic [31:0] a;
    act = 1'b0; we_i = 1'b0; re_i = 1'b0; addr_i = '0; wd_i = '0;
    ext_ack = 1'b0; ext_rd = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed sequence
    local_access(1'b0, 1'b1, 32'h0, 8'h00);
    local_access(1'b1, 1'b0, 32'h3, 8'h5C);
    check("reg_out_byte3", reg_out[31:24], 8'h5C);
    local_access(1'b0, 1'b1, 32'h3, 8'h00);
    local_access(1'b1, 1'b0, 32'h0, 8'hFF);
    check("id_byte_kept", reg_out[7:0], ID);
    ext_access(1'b0, 32'h0000_1042, 8'h00, 5, 8'h7E);

    // Timeout on an external write
    b  = ack_cnt;
    tb = tmo_cnt;
    start_strobe(1'b1, 1'b0, 32'h0000_10FF, 8'h33);
    check("tmo_ext_we", ext_we, 1);
    check("tmo_ext_addr", ext_addr, 8'hFF);
    for (int i = 0; i < 1100; i++) begin
      if (tmo_cnt > tb) break;
      @(posedge clk); #2;
    end
    check("timeout_seen", (tmo_cnt > tb), 1);
    check("timeout_latency", t_tmo - t_strobe, TMO);
    repeat (4) begin @(posedge clk); #1; end
    check("timeout_single_pulse", tmo_cnt - tb, 1);
    check("timeout_no_ack", ack_cnt - b, 0);
    act = 1'b0;
    local_access(1'b0, 1'b1, 32'h3, 8'h00);

    unmapped_access(1'b0, 1'b1, 32'h0000_0800);
    b = ack_cnt;
    local_access(1'b1, 1'b1, 32'h2, 8'h11);
    repeat (3) begin @(posedge clk); #1; end
    check("we_re_one_ack", ack_cnt - b, 1);
    check("we_re_byte2", reg_out[23:16], 8'h11);

    // Abort while waiting on the external side
    b  = ack_cnt;
    tb = tmo_cnt;
    start_strobe(1'b0, 1'b1, 32'h0000_1010, 8'h00);
    repeat (3) begin @(posedge clk); #1; end
    act = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    ext_ack = 1'b1; ext_rd = 8'h99;
    @(posedge clk); #1;
    ext_ack = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("abort_no_ack", ack_cnt - b, 0);
    check("abort_no_timeout", tmo_cnt - tb, 0);
    ext_access(1'b1, 32'h0000_1001, 8'hC3, 2, 8'h44);

    // Reset in the middle of an external wait
    local_access(1'b1, 1'b0, 32'h7, 8'hE1);
    b  = ack_cnt;
    sb = strobe_cnt;
    start_strobe(1'b0, 1'b1, 32'h0000_1020, 8'h00);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_reset_outputs("midrst");
    rst = 1'b0;
    act = 1'b0;
    ext_ack = 1'b1; ext_rd = 8'h66;
    @(posedge clk); #1;
    ext_ack = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("midrst_no_ack", ack_cnt - b, 0);
    check("midrst_one_strobe", strobe_cnt - sb, 1);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'($urandom_range(0, NREG - 1));
        1:       a = EXT_BASE + 32'($urandom_range(0, EXT_SPAN - 1));
        default: a = ($urandom_range(0, 1) == 0) ? 32'h10 + 32'($urandom_range(0, 32'hFEF))
                                                 : 32'h1100 + 32'($urandom_range(0, 32'hFFFF));
      endcase
      case (kind_of(a))
        0: begin
          if ($urandom_range(0, 1) == 0) local_access(1'b0, 1'b1, a, 8'h00);
          else local_access(1'b1, 1'($urandom_range(0, 1)), a, 8'($urandom));
        end
        1: ext_access(1'($urandom_range(0, 1)), a, 8'($urandom),
                      $urandom_range(0, 6), 8'($urandom));
        default: unmapped_access(1'($urandom_range(0, 1)), 1'b1, a);
      endcase
    end

    repeat (3) begin @(posedge clk); #1; end
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
